// File: rtl/pipe_redirect_ctrl.sv
// Pipeline control: merges stall requests into stall/bubble, arbitrates redirects
// into flush masks, and holds a redirect until the fetch stage accepts it.
module pipe_redirect_ctrl #(
    parameter int STAGES     = 5,
    parameter int ADDR_WIDTH = 32,
    parameter int BR_STAGE   = 2,
    parameter int EXC_STAGE  = 3,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [STAGES-1:0]     stall_req,
    input  logic                  predict_miss,
    input  logic [ADDR_WIDTH-1:0] real_addr,
    input  logic                  exp_en,
    input  logic [ADDR_WIDTH-1:0] trap_entry,
    input  logic                  e_ret,
    input  logic [ADDR_WIDTH-1:0] epc,
    input  logic                  if_redir_ready,
    output logic [STAGES-1:0]     stall,
    output logic [STAGES-1:0]     bubble,
    output logic [STAGES-1:0]     flush,
    output logic                  redir_valid,
    output logic [ADDR_WIDTH-1:0] flush_pc,
    output logic [CNT_WIDTH-1:0]  miss_cnt,
    output logic [CNT_WIDTH-1:0]  exc_cnt
);

    typedef enum logic [1:0] {IDLE, PEND_BR, PEND_EXC} state_t;

    localparam logic [STAGES-1:0] EXC_MASK = STAGES'((64'd1 << (EXC_STAGE + 1)) - 64'd1);
    localparam logic [STAGES-1:0] BR_MASK  = STAGES'((64'd1 << BR_STAGE) - 64'd1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic [CNT_WIDTH-1:0]  miss_cnt_q, exc_cnt_q;

    logic [STAGES-1:0]     raw_stall;
    logic [STAGES-1:0]     flush_int;
    logic [STAGES-1:0]     stall_int;
    logic [STAGES-1:0]     bubble_int;
    logic                  exc_ev, br_ev, any_ev;
    logic [ADDR_WIDTH-1:0] target;

    // A stall anywhere downstream must hold every younger stage behind it.
    genvar i;
    generate
        for (i = 0; i < STAGES; i++) begin : g_stage
            assign raw_stall[i] = |stall_req[STAGES-1:i];
            assign stall_int[i] = raw_stall[i] & ~flush_int[i];
            if (i == 0) begin : g_if
                assign bubble_int[i] = 1'b0;
            end else begin : g_rest
                assign bubble_int[i] = raw_stall[i-1] & ~raw_stall[i] & ~flush_int[i];
            end
        end
    endgenerate

    always_comb begin
        exc_ev = exp_en | e_ret;
        br_ev  = predict_miss & ~raw_stall[BR_STAGE] & ~exc_ev & (state_q != PEND_EXC);
        any_ev = exc_ev | br_ev;

        target = real_addr;
        if (exp_en)     target = trap_entry;
        else if (e_ret) target = epc;

        flush_int = '0;
        if (exc_ev)           flush_int = flush_int | EXC_MASK;
        if (br_ev)            flush_int = flush_int | BR_MASK;
        // Keep dropping wrong-path fetches until IF takes the redirect.
        if (state_q != IDLE)  flush_int[0] = 1'b1;

        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        if (any_ev) begin
            if (if_redir_ready) begin
                state_d = IDLE;
            end else begin
                pend_pc_d = target;
                state_d   = exc_ev ? PEND_EXC : PEND_BR;
            end
        end else if (state_q != IDLE && if_redir_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_pc_q  <= '0;
            miss_cnt_q <= '0;
            exc_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
            if (br_ev && miss_cnt_q != '1)
                miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
            if (exc_ev && exc_cnt_q != '1)
                exc_cnt_q <= exc_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Outputs are forced low while reset is held, even before the first edge.
    assign stall       = stall_int  & {STAGES{rst_n}};
    assign bubble      = bubble_int & {STAGES{rst_n}};
    assign flush       = flush_int  & {STAGES{rst_n}};
    assign redir_valid = (any_ev | (state_q != IDLE)) & rst_n;
    assign flush_pc    = (any_ev ? target : pend_pc_q) & {ADDR_WIDTH{rst_n}};
    assign miss_cnt    = miss_cnt_q & {CNT_WIDTH{rst_n}};
    assign exc_cnt     = exc_cnt_q  & {CNT_WIDTH{rst_n}};

endmodule

// File: tb/tb_pipe_redirect_ctrl.sv
// Scoreboard bench for pipe_redirect_ctrl: each cycle's expected outputs are
// queued when the stimulus is driven and compared mid-cycle.
module tb_pipe_redirect_ctrl;

    localparam logic [31:0] RA1 = 32'h1c000100;
    localparam logic [31:0] RA2 = 32'h1c000300;
    localparam logic [31:0] TE  = 32'h1c008000;
    localparam logic [31:0] EP  = 32'h1c000200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  stall_req;
    logic        predict_miss;
    logic [31:0] real_addr;
    logic        exp_en;
    logic [31:0] trap_entry;
    logic        e_ret;
    logic [31:0] epc;
    logic        if_redir_ready;
    logic [4:0]  stall, bubble, flush;
    logic        redir_valid;
    logic [31:0] flush_pc, miss_cnt, exc_cnt;

    typedef struct {
        string       tag;
        logic [4:0]  stall;
        logic [4:0]  bubble;
        logic [4:0]  flush;
        logic        rv;
        logic [31:0] pc;
        logic [31:0] mc;
        logic [31:0] ec;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    pipe_redirect_ctrl dut (
        .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .predict_miss(predict_miss),
        .real_addr(real_addr), .exp_en(exp_en), .trap_entry(trap_entry), .e_ret(e_ret),
        .epc(epc), .if_redir_ready(if_redir_ready), .stall(stall), .bubble(bubble),
        .flush(flush), .redir_valid(redir_valid), .flush_pc(flush_pc),
        .miss_cnt(miss_cnt), .exc_cnt(exc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
    task automatic step(input string tag, input logic rn, input logic [4:0] sreq,
                        input logic pm, input logic [31:0] ra, input logic ee,
                        input logic er, input logic rdy,
                        input logic [4:0] es, input logic [4:0] eb, input logic [4:0] ef,
                        input logic erv, input logic [31:0] epcv,
                        input logic [31:0] emc, input logic [31:0] eec);
        exp_t e, o;
        @(posedge clk);
        #1;
        rst_n = rn; stall_req = sreq; predict_miss = pm; real_addr = ra;
        exp_en = ee; e_ret = er; if_redir_ready = rdy;
        e = '{tag, es, eb, ef, erv, epcv, emc, eec};
        sb.push_back(e);
        @(negedge clk);
        o = sb.pop_front();
        chk({o.tag, ".stall"},  64'(stall),       64'(o.stall));
        chk({o.tag, ".bubble"}, 64'(bubble),      64'(o.bubble));
        chk({o.tag, ".flush"},  64'(flush),       64'(o.flush));
        chk({o.tag, ".rv"},     64'(redir_valid), 64'(o.rv));
        chk({o.tag, ".pc"},     64'(flush_pc),    64'(o.pc));
        chk({o.tag, ".miss"},   64'(miss_cnt),    64'(o.mc));
        chk({o.tag, ".exc"},    64'(exc_cnt),     64'(o.ec));
    endtask

    initial begin
        rst_n = 1'b0; stall_req = '0; predict_miss = 0; real_addr = RA1;
        exp_en = 0; trap_entry = TE; e_ret = 0; epc = EP; if_redir_ready = 0;

        // reset with every input high
        step("rst0", 0, 5'b11111, 1, RA1, 1, 1, 1, 5'h0, 5'h0, 5'h0, 0, 0, 0, 0);
        step("rst1", 0, 5'b11111, 1, RA1, 1, 1, 1, 5'h0, 5'h0, 5'h0, 0, 0, 0, 0);
        step("idle", 1, 5'b00000, 0, RA1, 0, 0, 1, 5'h0, 5'h0, 5'h0, 0, 0, 0, 0);
        // stall backs up from stage 3
        step("stl3", 1, 5'b01000, 0, RA1, 0, 0, 1, 5'b01111, 5'b10000, 5'h0, 0, 0, 0, 0);
        // mispredict accepted immediately
        step("br",   1, 5'b00000, 1, RA1, 0, 0, 1, 5'h0, 5'h0, 5'b00011, 1, RA1, 0, 0);
        step("br+1", 1, 5'b00000, 0, RA1, 0, 0, 1, 5'h0, 5'h0, 5'h0, 0, 0, 1, 0);
        // exception beats mispredict
        step("exc",  1, 5'b00000, 1, RA1, 1, 0, 1, 5'h0, 5'h0, 5'b01111, 1, TE, 1, 0);
        step("exc+1",1, 5'b00000, 0, RA1, 0, 0, 1, 5'h0, 5'h0, 5'h0, 0, 0, 1, 1);
        // ertn held pending; mispredict ignored while PEND_EXC
        step("ert1", 1, 5'b00000, 0, RA1, 0, 1, 0, 5'h0, 5'h0, 5'b01111, 1, EP, 1, 1);
        step("ert2", 1, 5'b00000, 1, RA1, 0, 0, 0, 5'h0, 5'h0, 5'b00001, 1, EP, 1, 2);
        step("ert3", 1, 5'b00000, 0, RA1, 0, 0, 0, 5'h0, 5'h0, 5'b00001, 1, EP, 1, 2);
        step("ert4", 1, 5'b00000, 0, RA1, 0, 0, 1, 5'h0, 5'h0, 5'b00001, 1, EP, 1, 2);
        step("ert+", 1, 5'b00000, 0, RA1, 0, 0, 1, 5'h0, 5'h0, 5'h0, 0, EP, 1, 2);
        // mispredict while BR_STAGE stalled is dropped, then retried
        step("brs",  1, 5'b01000, 1, RA1, 0, 0, 1, 5'b01111, 5'b10000, 5'h0, 0, EP, 1, 2);
        step("brr",  1, 5'b00000, 1, RA1, 0, 0, 1, 5'h0, 5'h0, 5'b00011, 1, RA1, 1, 2);
        // flush overrides stall/bubble; PEND_BR overridden by br then by exc
        step("pb1",  1, 5'b00001, 1, RA1, 0, 0, 0, 5'h0, 5'h0, 5'b00011, 1, RA1, 2, 2);
        step("pb2",  1, 5'b00000, 1, RA2, 0, 0, 0, 5'h0, 5'h0, 5'b00011, 1, RA2, 3, 2);
        step("pb3",  1, 5'b00000, 0, RA2, 0, 0, 0, 5'h0, 5'h0, 5'b00001, 1, RA2, 4, 2);
        step("pe1",  1, 5'b00000, 0, RA2, 1, 0, 0, 5'h0, 5'h0, 5'b01111, 1, TE, 4, 2);
        step("pe2",  1, 5'b00000, 1, RA2, 0, 0, 1, 5'h0, 5'h0, 5'b00001, 1, TE, 4, 3);
        step("pe+",  1, 5'b00000, 0, RA2, 0, 0, 1, 5'h0, 5'h0, 5'h0, 0, TE, 4, 3);
        // reset while pending discards the redirect
        step("rp1",  1, 5'b00000, 0, RA1, 0, 1, 0, 5'h0, 5'h0, 5'b01111, 1, EP, 4, 3);
        step("rp2",  0, 5'b00000, 0, RA1, 0, 0, 0, 5'h0, 5'h0, 5'h0, 0, 0, 0, 0);
        step("rp3",  1, 5'b00000, 0, RA1, 0, 0, 0, 5'h0, 5'h0, 5'h0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
